// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: load size codes,
// queue occupancy states and the buffered writeback entry.
package wb_pkg;

  localparam int WB_DEPTH = 2;

  localparam logic [1:0] LD_WORD = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_BYTE = 2'b10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } q_state_e;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
    logic        reg_write;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_ext.sv
// Sub-word load aligner: picks the big-endian lane addressed by the byte
// offset, sign/zero extends it and flags misaligned half/word accesses.
module wb_load_ext
  import wb_pkg::*;
(
  input  logic [31:0] mem_data,
  input  logic [1:0]  offset,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  output logic [31:0] data,
  output logic        misalign
);

  logic [15:0] half_s;
  logic [7:0]  byte_s;

  // lane select and extension; the reserved size code behaves as a word
  always_comb begin
    data     = mem_data;
    misalign = 1'b0;
    half_s   = 16'd0;
    byte_s   = 8'd0;
    case (ld_size)
      LD_HALF: begin
        half_s   = offset[1] ? mem_data[15:0] : mem_data[31:16];
        data     = {{16{half_s[15] & ~ld_unsigned}}, half_s};
        misalign = offset[0];
      end
      LD_BYTE: begin
        case (offset)
          2'd0:    byte_s = mem_data[31:24];
          2'd1:    byte_s = mem_data[23:16];
          2'd2:    byte_s = mem_data[15:8];
          default: byte_s = mem_data[7:0];
        endcase
        data = {{24{byte_s[7] & ~ld_unsigned}}, byte_s};
      end
      default: begin
        data     = mem_data;
        misalign = (offset != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: result select, 2-entry buffer driving the register file
// write port, forwarding tap and retire counter. Sub-word loads need WB_LOAD_EXT_EN.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_wr_addr,
  input  logic             in_reg_write,
  input  logic             in_mem_to_reg,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_mem_data,
  input  logic [1:0]       in_ld_size,
  input  logic             in_ld_unsigned,
  input  logic             hold,
  output logic [5:0]       rf_wr_addr,
  output logic [31:0]      rf_wr_data,
  output logic             rf_reg_write,
  output logic             fwd_valid,
  output logic [5:0]       fwd_addr,
  output logic [31:0]      fwd_data,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retire_cnt
);

  q_state_e         state_r;
  q_state_e         state_s;
  wb_entry_t        slot_r [DEPTH];
  wb_entry_t        new_s;
  logic [31:0]      ld_data_s;
  logic             ld_misalign_s;
  logic             misalign_s;
  logic             push_s;
  logic             pop_s;
  logic             head_valid_s;
  logic             misalign_r;
  logic [CNT_W-1:0] cnt_r;

`ifdef WB_LOAD_EXT_EN
  wb_load_ext u_load_ext (
    .mem_data    (in_mem_data),
    .offset      (in_alu_result[1:0]),
    .ld_size     (in_ld_size),
    .ld_unsigned (in_ld_unsigned),
    .data        (ld_data_s),
    .misalign    (ld_misalign_s)
  );
`else
  logic unused_s;
  assign unused_s      = ^{in_ld_size, in_ld_unsigned};
  assign ld_data_s     = in_mem_data;
  assign ld_misalign_s = 1'b0;
`endif

  assign head_valid_s = (state_r != EMPTY);
  assign in_ready     = (state_r != FULL);
  assign push_s       = in_valid & in_ready;
  assign pop_s        = head_valid_s & ~hold;

  // build the entry at accept time; r0 and misaligned loads never write
  always_comb begin
    misalign_s      = in_mem_to_reg & ld_misalign_s;
    new_s.addr      = in_wr_addr;
    new_s.data      = in_mem_to_reg ? ld_data_s : in_alu_result;
    new_s.reg_write = in_reg_write & (in_wr_addr != 6'd0) & ~misalign_s;
  end

  // occupancy next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      EMPTY: begin
        if (push_s) state_s = ONE;
        else        state_s = EMPTY;
      end
      ONE: begin
        if (push_s && !pop_s)      state_s = FULL;
        else if (!push_s && pop_s) state_s = EMPTY;
        else                       state_s = ONE;
      end
      FULL: begin
        if (pop_s) state_s = ONE;
        else       state_s = FULL;
      end
      default: state_s = EMPTY;
    endcase
  end

  // occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= EMPTY;
    else        state_r <= state_s;
  end

  // slot 0 is always the head; slot 1 shifts down on a pop from FULL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slot_r[i] <= '0;
    end else begin
      case (state_r)
        EMPTY: if (push_s) slot_r[0] <= new_s;
        ONE: begin
          if (push_s && pop_s) slot_r[0] <= new_s;
          else if (push_s)     slot_r[1] <= new_s;
        end
        FULL: if (pop_s) slot_r[0] <= slot_r[1];
        default: slot_r[0] <= slot_r[0];
      endcase
    end
  end

  // misalign pulse and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_r <= 1'b0;
      cnt_r      <= '0;
    end else begin
      misalign_r <= push_s & misalign_s;
      if (pop_s) cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign fwd_valid    = head_valid_s & slot_r[0].reg_write;
  assign fwd_addr     = head_valid_s ? slot_r[0].addr : 6'd0;
  assign fwd_data     = head_valid_s ? slot_r[0].data : 32'd0;
  assign rf_reg_write = fwd_valid & ~hold;
  assign rf_wr_addr   = fwd_addr;
  assign rf_wr_data   = fwd_data;
  assign misalign_err = misalign_r;
  assign retire_cnt   = cnt_r;

endmodule
